vector_dispatch: RTL and testbench
==================================

VECTOR_DISPATCH -- requirements
Module: vector_dispatch

Interface
REQ-001 The block SHALL have parameter lanes_p, default 2, giving the number of lanes driven and monitored.
REQ-002 The block SHALL have parameter els_p, default 32, giving the number of vector registers; v_addr_width_lp = BSG_SAFE_CLOG2(els_p).
REQ-003 The block SHALL have parameter vdw_p, default 8, giving the scalar operand width.
REQ-004 The block SHALL have parameter op_width_p, default 4, giving the opcode width; the opcode is opaque to this block.
REQ-005 The block SHALL have parameter timeout_p, default 64, giving the watchdog limit in cycles (used only with the macro).
REQ-006 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-007 reset_i  in  1  synchronous, active-high reset.
REQ-008 v_i / ready_o  in / out  1 / 1  instruction valid/ready; accepted on a cycle with v_i & ready_o.
REQ-009 op_i, vd_i, vs1_i, vs2_i, scalar_i  in  op_width_p, v_addr_width_lp x3, vdw_p  instruction fields.
REQ-010 lane_op_o, vd_o, vs1_o, vs2_o, lane_scalar_o  out  same widths  latched fields broadcast to all lanes.
REQ-011 lane_start_o  out  1  one-cycle start pulse broadcast to all lanes.
REQ-012 lane_done_i  in  lanes_p  per-lane done; level or pulse accepted.
REQ-013 done_o  out  1  one-cycle instruction-retired pulse.
REQ-014 busy_o  out  1  high in ISSUE and WAIT.
REQ-015 retire_count_o  out  16  count of retired instructions; wraps 0xFFFF->0x0000.
REQ-016 err_o  out  1  sticky watchdog error flag.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT, COMPLETE.
REQ-018 ready_o SHALL be 1 in IDLE and COMPLETE and 0 in ISSUE and WAIT.
REQ-019 On acceptance in IDLE or COMPLETE, the block SHALL latch all fields into the broadcast outputs and go to ISSUE on the next cycle.
REQ-020 The broadcast outputs SHALL stay stable until the next acceptance.
REQ-021 In ISSUE, the block SHALL assert lane_start_o for exactly one cycle, clear the done mask, and go to WAIT.
REQ-022 In ISSUE, lane_done_i SHALL be ignored.
REQ-023 In WAIT, the block SHALL OR lane_done_i into a sticky lanes_p-bit mask.
REQ-024 The block SHALL go to COMPLETE in the cycle after (mask | lane_done_i) is all ones.
REQ-025 In COMPLETE, the block SHALL assert done_o for one cycle and increment retire_count_o by 1.
REQ-026 If v_i is high in COMPLETE, the block SHALL accept and go to ISSUE; otherwise it SHALL go to IDLE.
REQ-027 With v_i held from a done_o cycle, lane_start_o SHALL fire on the next cycle (zero bubble).
REQ-028 v_i during ISSUE or WAIT SHALL be ignored: no latch and no state change.
REQ-029 The minimum latency SHALL be: accept at cycle N, lane_start_o at N+1, all lanes done at N+2, done_o at N+3.

Reset
REQ-030 Synchronous reset SHALL force IDLE and zero the following: mask, watchdog counter, retire_count_o, err_o, lane_start_o, done_o, busy_o and all broadcast outputs.
REQ-031 After reset, ready_o SHALL be 1.
REQ-032 A reset in any state SHALL discard the in-flight instruction with no done_o and no count increment.
REQ-033 Reset SHALL take priority over v_i and lane_done_i in the same cycle.

Configuration
REQ-034 Macro VECTOR_DISPATCH_TIMEOUT_EN defined: a counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-035 With the macro defined, if the counter reaches timeout_p-1 with the mask incomplete, the block SHALL set err_o (sticky until reset) and go to COMPLETE.
REQ-036 A timeout retirement SHALL still pulse done_o and increment retire_count_o.
REQ-037 Macro undefined: no counter SHALL exist, err_o SHALL be tied to 0, and WAIT SHALL be held indefinitely.

Verification
REQ-038 Reset, then v_i=1 op=4'b0000 vd=3 vs1=1 vs2=2 scalar=8'h10 at cycle 0, both lanes done at cycle 4 -> lane_start_o at cycle 1 with vd_o=3 and lane_scalar_o=8'h10, done_o at cycle 5, retire_count_o=1.
REQ-039 Staggered done: lane0 pulses at cycle 3, lane1 pulses at cycle 7 -> done_o at cycle 8 only, busy_o high for cycles 1-7.
REQ-040 Back-to-back: second instruction op=4'b1001 held valid during the done_o cycle -> accepted there, lane_start_o the next cycle, lane_op_o=4'b1001.
REQ-041 v_i with vd=7 during WAIT -> ignored, vd_o unchanged.
REQ-042 Reset asserted in WAIT -> IDLE next cycle, ready_o=1, no done_o, retire_count_o unchanged from 0.
REQ-043 Macro defined, timeout_p=16, lane1 never done -> err_o=1 and done_o 16 cycles after WAIT entry; err_o still 1 after the next instruction.

Source files
------------

// File: rtl/vector_dispatch.sv
// Single-instruction vector dispatcher: latches one instruction, broadcasts a start pulse to all
// lanes and retires once every lane has reported done. Optional watchdog: VECTOR_DISPATCH_TIMEOUT_EN.
module vector_dispatch #(
    parameter int unsigned lanes_p    = 2,
    parameter int unsigned els_p      = 32,
    parameter int unsigned vdw_p      = 8,
    parameter int unsigned op_width_p = 4,
    parameter int unsigned timeout_p  = 64,
    localparam int unsigned v_addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [op_width_p-1:0]      op_i,
    input  logic [v_addr_width_lp-1:0] vd_i,
    input  logic [v_addr_width_lp-1:0] vs1_i,
    input  logic [v_addr_width_lp-1:0] vs2_i,
    input  logic [vdw_p-1:0]           scalar_i,

    output logic [op_width_p-1:0]      lane_op_o,
    output logic [v_addr_width_lp-1:0] vd_o,
    output logic [v_addr_width_lp-1:0] vs1_o,
    output logic [v_addr_width_lp-1:0] vs2_o,
    output logic [vdw_p-1:0]           lane_scalar_o,
    output logic                       lane_start_o,
    input  logic [lanes_p-1:0]         lane_done_i,

    output logic                       done_o,
    output logic                       busy_o,
    output logic [15:0]                retire_count_o,
    output logic                       err_o
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StWait     = 2'd2,
        StComplete = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [lanes_p-1:0]         mask_q, mask_d;
    logic [op_width_p-1:0]      op_q;
    logic [v_addr_width_lp-1:0] vd_q, vs1_q, vs2_q;
    logic [vdw_p-1:0]           scalar_q;
    logic [15:0]                count_q;

    logic accept;
    logic all_done;
    logic timeout;

    assign ready_o  = (state_q == StIdle) || (state_q == StComplete);
    assign accept   = v_i && ready_o;
    // Completion looks at the live inputs so a lane finishing this cycle counts immediately.
    assign all_done = &(mask_q | lane_done_i);

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        lane_start_o = 1'b0;
        done_o       = 1'b0;
        busy_o       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StIssue;
            end
            StIssue: begin
                lane_start_o = 1'b1;
                busy_o       = 1'b1;
                mask_d       = '0;
                state_d      = StWait;
            end
            StWait: begin
                busy_o = 1'b1;
                mask_d = mask_q | lane_done_i;
                if (all_done || timeout) state_d = StComplete;
            end
            StComplete: begin
                done_o  = 1'b1;
                state_d = accept ? StIssue : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_q     <= '0;
            vd_q     <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            scalar_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                op_q     <= op_i;
                vd_q     <= vd_i;
                vs1_q    <= vs1_i;
                vs2_q    <= vs2_i;
                scalar_q <= scalar_i;
            end
            if (state_q == StComplete) count_q <= count_q + 16'd1;
        end
    end

    assign lane_op_o      = op_q;
    assign vd_o           = vd_q;
    assign vs1_o          = vs1_q;
    assign vs2_o          = vs2_q;
    assign lane_scalar_o  = scalar_q;
    assign retire_count_o = count_q;

`ifdef VECTOR_DISPATCH_TIMEOUT_EN
    localparam int unsigned cnt_width_lp = $clog2(timeout_p + 1);

    logic [cnt_width_lp-1:0] wd_cnt_q;
    logic                    err_q;

    assign timeout = (wd_cnt_q == cnt_width_lp'(timeout_p - 1));

    // Counter is cleared in ISSUE, the only way into WAIT, so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == StIssue) begin
                wd_cnt_q <= '0;
            end else if (state_q == StWait) begin
                wd_cnt_q <= wd_cnt_q + cnt_width_lp'(1);
            end
            if ((state_q == StWait) && !all_done && timeout) err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign err_o          = 1'b0;
    assign unused_timeout = ^timeout_p;
`endif

endmodule

// File: tb/tb_vector_dispatch.sv
// Directed table-driven bench for vector_dispatch, plus hand sequences for reset-in-flight,
// staggered lane completion and the watchdog (or its absence).
module tb_vector_dispatch;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic        ready_o;
    logic [3:0]  op_i;
    logic [4:0]  vd_i, vs1_i, vs2_i;
    logic [7:0]  scalar_i;
    logic [3:0]  lane_op_o;
    logic [4:0]  vd_o, vs1_o, vs2_o;
    logic [7:0]  lane_scalar_o;
    logic        lane_start_o;
    logic [1:0]  lane_done_i;
    logic        done_o, busy_o, err_o;
    logic [15:0] retire_count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    vector_dispatch #(
        .lanes_p   (2),
        .els_p     (32),
        .vdw_p     (8),
        .op_width_p(4),
        .timeout_p (16)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .v_i           (v_i),
        .ready_o       (ready_o),
        .op_i          (op_i),
        .vd_i          (vd_i),
        .vs1_i         (vs1_i),
        .vs2_i         (vs2_i),
        .scalar_i      (scalar_i),
        .lane_op_o     (lane_op_o),
        .vd_o          (vd_o),
        .vs1_o         (vs1_o),
        .vs2_o         (vs2_o),
        .lane_scalar_o (lane_scalar_o),
        .lane_start_o  (lane_start_o),
        .lane_done_i   (lane_done_i),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .retire_count_o(retire_count_o),
        .err_o         (err_o)
    );

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [4:0]  vd, vs1, vs2;
        logic [7:0]  sc;
        logic [1:0]  ld;
        logic        e_ready, e_start, e_done, e_busy;
        logic [3:0]  e_op;
        logic [4:0]  e_vd, e_vs1, e_vs2;
        logic [7:0]  e_sc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] vd,
                         input logic [7:0] sc, input logic [1:0] ld);
        v_i         = v;
        op_i        = op;
        vd_i        = vd;
        vs1_i       = 5'd0;
        vs2_i       = 5'd0;
        scalar_i    = sc;
        lane_done_i = ld;
    endtask

    initial begin
        // Cycle 0 accepts the first instruction; outputs are the values seen during each cycle.
        tbl[0]  = '{1'b1, 4'h0, 5'd3, 5'd1, 5'd2, 8'h10, 2'b00,
                    1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 16'd0};
        tbl[1]  = '{1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 2'b11,
                    1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 5'd3, 5'd1, 5'd2, 8'h10, 16'd0};
        tbl[2]  = '{1'b1, 4'h5, 5'd7, 5'd7, 5'd7, 8'hff, 2'b00,
                    1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'd3, 5'd1, 5'd2, 8'h10, 16'd0};
        tbl[3]  = '{1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 2'b00,
                    1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'd3, 5'd1, 5'd2, 8'h10, 16'd0};
        tbl[4]  = '{1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 2'b11,
                    1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 5'd3, 5'd1, 5'd2, 8'h10, 16'd0};
        tbl[5]  = '{1'b1, 4'h9, 5'd5, 5'd4, 5'd6, 8'h22, 2'b00,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 5'd3, 5'd1, 5'd2, 8'h10, 16'd0};
        tbl[6]  = '{1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 2'b11,
                    1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 5'd5, 5'd4, 5'd6, 8'h22, 16'd1};
        tbl[7]  = '{1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 2'b01,
                    1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 5'd5, 5'd4, 5'd6, 8'h22, 16'd1};
        tbl[8]  = '{1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 2'b00,
                    1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 5'd5, 5'd4, 5'd6, 8'h22, 16'd1};
        tbl[9]  = '{1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 2'b10,
                    1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 5'd5, 5'd4, 5'd6, 8'h22, 16'd1};
        tbl[10] = '{1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 2'b00,
                    1'b1, 1'b0, 1'b1, 1'b0, 4'h9, 5'd5, 5'd4, 5'd6, 8'h22, 16'd1};
        tbl[11] = '{1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00, 2'b00,
                    1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 5'd5, 5'd4, 5'd6, 8'h22, 16'd2};

        reset_i = 1'b1;
        drive(1'b0, 4'h0, 5'd0, 8'h00, 2'b00);
        step();
        step();
        reset_i = 1'b0;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_start", 32'(lane_start_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_vd", 32'(vd_o), 32'd0);
        check("rst_count", 32'(retire_count_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);

        // Reset while in WAIT, with valid and lane-done also high: everything is discarded.
        drive(1'b1, 4'h3, 5'd9, 8'h44, 2'b00);
        step();
        drive(1'b0, 4'h0, 5'd0, 8'h00, 2'b00);
        step();
        check("wrst_in_wait", 32'(busy_o), 32'd1);
        reset_i = 1'b1;
        drive(1'b1, 4'h1, 5'd1, 8'h01, 2'b11);
        step();
        reset_i = 1'b0;
        drive(1'b0, 4'h0, 5'd0, 8'h00, 2'b00);
        check("wrst_ready", 32'(ready_o), 32'd1);
        check("wrst_busy", 32'(busy_o), 32'd0);
        check("wrst_done", 32'(done_o), 32'd0);
        check("wrst_vd", 32'(vd_o), 32'd0);
        check("wrst_count", 32'(retire_count_o), 32'd0);
        step();
        check("wrst_done2", 32'(done_o), 32'd0);
        check("wrst_start2", 32'(lane_start_o), 32'd0);
        check("wrst_count2", 32'(retire_count_o), 32'd0);

        foreach (tbl[i]) begin
            v_i         = tbl[i].v;
            op_i        = tbl[i].op;
            vd_i        = tbl[i].vd;
            vs1_i       = tbl[i].vs1;
            vs2_i       = tbl[i].vs2;
            scalar_i    = tbl[i].sc;
            lane_done_i = tbl[i].ld;
            #1;
            check($sformatf("tbl%0d_ready", i), 32'(ready_o), 32'(tbl[i].e_ready));
            check($sformatf("tbl%0d_start", i), 32'(lane_start_o), 32'(tbl[i].e_start));
            check($sformatf("tbl%0d_done", i), 32'(done_o), 32'(tbl[i].e_done));
            check($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_op", i), 32'(lane_op_o), 32'(tbl[i].e_op));
            check($sformatf("tbl%0d_vd", i), 32'(vd_o), 32'(tbl[i].e_vd));
            check($sformatf("tbl%0d_vs1", i), 32'(vs1_o), 32'(tbl[i].e_vs1));
            check($sformatf("tbl%0d_vs2", i), 32'(vs2_o), 32'(tbl[i].e_vs2));
            check($sformatf("tbl%0d_sc", i), 32'(lane_scalar_o), 32'(tbl[i].e_sc));
            check($sformatf("tbl%0d_cnt", i), 32'(retire_count_o), 32'(tbl[i].e_cnt));
            step();
        end

        // Staggered lane pulses: lane0 at cycle 3, lane1 at cycle 7, retire at cycle 8.
        for (int c = 0; c < 10; c++) begin
            drive(c == 0, 4'h2, 5'd11, 8'h33,
                  (c == 3) ? 2'b01 : ((c == 7) ? 2'b10 : 2'b00));
            #1;
            check($sformatf("stag%0d_busy", c), 32'(busy_o), 32'((c >= 1) && (c <= 7)));
            check($sformatf("stag%0d_done", c), 32'(done_o), 32'(c == 8));
            check($sformatf("stag%0d_start", c), 32'(lane_start_o), 32'(c == 1));
            step();
        end
        check("stag_count", 32'(retire_count_o), 32'd3);
        check("stag_vd", 32'(vd_o), 32'd11);

`ifdef VECTOR_DISPATCH_TIMEOUT_EN
        // WAIT is entered at cycle 2; lane1 never finishes, watchdog retires at cycle 18.
        for (int c = 0; c < 21; c++) begin
            drive(c == 0, 4'h7, 5'd2, 8'h55, 2'b01);
            #1;
            check($sformatf("wd%0d_done", c), 32'(done_o), 32'(c == 18));
            check($sformatf("wd%0d_err", c), 32'(err_o), 32'(c >= 18));
            step();
        end
        check("wd_count", 32'(retire_count_o), 32'd4);
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, 4'h1, 5'd1, 8'h01, (c == 2) ? 2'b11 : 2'b00);
            #1;
            check($sformatf("wd2_%0d_done", c), 32'(done_o), 32'(c == 3));
            check($sformatf("wd2_%0d_err", c), 32'(err_o), 32'd1);
            step();
        end
        check("wd2_count", 32'(retire_count_o), 32'd5);
`else
        // Without the watchdog, an unfinished lane holds WAIT indefinitely.
        drive(1'b1, 4'h7, 5'd2, 8'h55, 2'b01);
        step();
        drive(1'b0, 4'h0, 5'd0, 8'h00, 2'b01);
        for (int c = 0; c < 80; c++) begin
            step();
            if (c % 20 == 19) begin
                check($sformatf("hold%0d_busy", c), 32'(busy_o), 32'd1);
                check($sformatf("hold%0d_done", c), 32'(done_o), 32'd0);
                check($sformatf("hold%0d_err", c), 32'(err_o), 32'd0);
            end
        end
        lane_done_i = 2'b10;
        step();
        lane_done_i = 2'b00;
        check("hold_release_done", 32'(done_o), 32'd1);
        check("hold_release_err", 32'(err_o), 32'd0);
        step();
        check("hold_count", 32'(retire_count_o), 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
